// File: rtl/if_id_stage.sv
// Fetch stage: owns the PC and the IF/ID pipeline register, applies hazard-unit
// stall/flush controls, and keeps saturating stall/flush counters plus a sticky protocol flag.
`timescale 1ns/1ps
module if_id_stage #(
    parameter int unsigned              PC_WIDTH    = 32,
    parameter int unsigned              INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0,
    parameter int unsigned              CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   PCWrite_i,
    input  logic                   IF_IDWrite_i,
    input  logic                   Flush_i,
    input  logic [PC_WIDTH-1:0]    PC_next_i,
    input  logic [INSTR_WIDTH-1:0] Instr_i,
    output logic [PC_WIDTH-1:0]    PC_o,
    output logic [PC_WIDTH-1:0]    IF_ID_PC_o,
    output logic [INSTR_WIDTH-1:0] IF_ID_Instr_o,
    output logic                   IF_ID_Valid_o,
    output logic [1:0]             State_o,
    output logic [CNT_WIDTH-1:0]   Stall_cnt_o,
    output logic [CNT_WIDTH-1:0]   Stall_run_o,
    output logic [CNT_WIDTH-1:0]   Flush_cnt_o,
    output logic                   Protocol_err_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        FLUSH = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [CNT_WIDTH-1:0]  stall_cnt_inc, stall_run_inc, flush_cnt_inc;

    // BOOT has no exits of its own: every state follows the same control priority.
    always_comb begin
        state_d = state_q;
        if (Flush_i)
            state_d = FLUSH;
        else if (!IF_IDWrite_i)
            state_d = STALL;
        else
            state_d = RUN;
    end

    always_comb begin
        pc_plus4      = PC_o + PC_WIDTH'(4);
        stall_cnt_inc = (&Stall_cnt_o) ? Stall_cnt_o : Stall_cnt_o + CNT_WIDTH'(1);
        stall_run_inc = (&Stall_run_o) ? Stall_run_o : Stall_run_o + CNT_WIDTH'(1);
        flush_cnt_inc = (&Flush_cnt_o) ? Flush_cnt_o : Flush_cnt_o + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= BOOT;
            PC_o           <= RESET_PC;
            IF_ID_PC_o     <= '0;
            IF_ID_Instr_o  <= '0;
            IF_ID_Valid_o  <= 1'b0;
            Stall_cnt_o    <= '0;
            Stall_run_o    <= '0;
            Flush_cnt_o    <= '0;
            Protocol_err_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (Flush_i) begin
                PC_o          <= PC_next_i;
                IF_ID_PC_o    <= '0;
                IF_ID_Instr_o <= '0;
                IF_ID_Valid_o <= 1'b0;
                Flush_cnt_o   <= flush_cnt_inc;
                Stall_run_o   <= '0;
            end else if (!IF_IDWrite_i) begin
                if (PCWrite_i)
                    PC_o <= PC_next_i;
                Stall_cnt_o <= stall_cnt_inc;
                Stall_run_o <= stall_run_inc;
            end else begin
                IF_ID_Instr_o <= Instr_i;
                IF_ID_PC_o    <= pc_plus4;
                IF_ID_Valid_o <= 1'b1;
                if (PCWrite_i)
                    PC_o <= PC_next_i;
                Stall_run_o <= '0;
            end
            // Mismatched PC/IF-ID writes lose or duplicate a fetch; flag it until reset.
            if (!Flush_i && (PCWrite_i != IF_IDWrite_i))
                Protocol_err_o <= 1'b1;
        end
    end

    assign State_o = state_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: run, stall, flush, PC+4 wrap, protocol flag,
// counter saturation (CNT_WIDTH=4) and asynchronous mid-run reset.
`timescale 1ns/1ps
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pcw, ifw, fl;
    logic [31:0] pc_next, instr;
    logic [31:0] pc_o, ifid_pc;
    logic [31:0] ifid_instr;
    logic        valid;
    logic [1:0]  state;
    logic [3:0]  stall_cnt, stall_run, flush_cnt;
    logic        perr;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    if_id_stage #(
        .PC_WIDTH   (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0),
        .CNT_WIDTH  (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .PCWrite_i     (pcw),
        .IF_IDWrite_i  (ifw),
        .Flush_i       (fl),
        .PC_next_i     (pc_next),
        .Instr_i       (instr),
        .PC_o          (pc_o),
        .IF_ID_PC_o    (ifid_pc),
        .IF_ID_Instr_o (ifid_instr),
        .IF_ID_Valid_o (valid),
        .State_o       (state),
        .Stall_cnt_o   (stall_cnt),
        .Stall_run_o   (stall_run),
        .Flush_cnt_o   (flush_cnt),
        .Protocol_err_o(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic w, input logic f,
                         input logic [31:0] nx, input logic [31:0] ins);
        pcw = p; ifw = w; fl = f; pc_next = nx; instr = ins;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0);
        #3;
        chk("rst_pc",    pc_o, 32'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_state", state, 2'b00);
        chk("rst_perr",  perr, 1'b0);
        tick();
        rst_i = 1'b1;

        // Run: fetches land in IF/ID one cycle behind PC
        drive(1, 1, 0, 32'd4, 32'hA);
        tick();
        chk("run1_pc",    pc_o, 32'd4);
        chk("run1_instr", ifid_instr, 32'hA);
        chk("run1_ifpc",  ifid_pc, 32'd4);
        chk("run1_valid", valid, 1'b1);
        chk("run1_state", state, 2'b01);
        drive(1, 1, 0, 32'd8, 32'hB);
        tick();
        chk("run2_instr", ifid_instr, 32'hB);
        chk("run2_ifpc",  ifid_pc, 32'd8);
        drive(1, 1, 0, 32'd12, 32'hC);
        tick();
        chk("run3_pc",    pc_o, 32'd12);
        chk("run3_instr", ifid_instr, 32'hC);
        chk("run3_ifpc",  ifid_pc, 32'd12);

        // Stall two cycles
        drive(0, 0, 0, 32'd16, 32'hDEAD);
        tick();
        chk("st1_pc",    pc_o, 32'd12);
        chk("st1_state", state, 2'b10);
        chk("st1_run",   stall_run, 4'd1);
        tick();
        chk("st2_pc",    pc_o, 32'd12);
        chk("st2_instr", ifid_instr, 32'hC);
        chk("st2_ifpc",  ifid_pc, 32'd12);
        chk("st2_cnt",   stall_cnt, 4'd2);
        chk("st2_run",   stall_run, 4'd2);
        drive(1, 1, 0, 32'd16, 32'hD);
        tick();
        chk("res_run",   stall_run, 4'd0);
        chk("res_cnt",   stall_cnt, 4'd2);
        chk("res_instr", ifid_instr, 32'hD);
        chk("res_ifpc",  ifid_pc, 32'd16);
        chk("res_state", state, 2'b01);

        // Flush overrides stall, PC loads despite PCWrite=0
        drive(0, 0, 1, 32'h80, 32'h55);
        tick();
        chk("fl_pc",    pc_o, 32'h80);
        chk("fl_instr", ifid_instr, 32'h0);
        chk("fl_ifpc",  ifid_pc, 32'h0);
        chk("fl_valid", valid, 1'b0);
        chk("fl_state", state, 2'b11);
        chk("fl_cnt",   flush_cnt, 4'd1);
        chk("fl_scnt",  stall_cnt, 4'd2);
        chk("fl_perr",  perr, 1'b0);

        // PC+4 wrap
        drive(1, 1, 0, 32'hFFFF_FFFC, 32'hE);
        tick();
        chk("wr1_pc",   pc_o, 32'hFFFF_FFFC);
        chk("wr1_ifpc", ifid_pc, 32'h84);
        drive(1, 1, 0, 32'h0, 32'hF);
        tick();
        chk("wr2_ifpc",  ifid_pc, 32'h0);
        chk("wr2_instr", ifid_instr, 32'hF);
        chk("wr2_valid", valid, 1'b1);

        // Protocol violation: PC advances, IF/ID holds
        drive(1, 0, 0, 32'h200, 32'h77);
        tick();
        chk("pe_flag",  perr, 1'b1);
        chk("pe_pc",    pc_o, 32'h200);
        chk("pe_instr", ifid_instr, 32'hF);
        chk("pe_state", state, 2'b10);
        chk("pe_cnt",   stall_cnt, 4'd3);
        drive(1, 1, 0, 32'h204, 32'h11);
        tick();
        chk("pe_sticky", perr, 1'b1);
        chk("pe_run0",   stall_run, 4'd0);

        // Saturation: 20 stalls on top of 3
        drive(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("sat12_cnt", stall_cnt, 4'd15);
        chk("sat12_run", stall_run, 4'd12);
        for (int i = 0; i < 8; i++) tick();
        chk("sat20_cnt", stall_cnt, 4'd15);
        chk("sat20_run", stall_run, 4'd15);
        chk("sat_perr",  perr, 1'b1);

        // Mid-run asynchronous reset with PC=0x40
        drive(0, 0, 1, 32'h40, 32'h0);
        tick();
        chk("pre_rst_pc", pc_o, 32'h40);
        drive(1, 1, 0, 32'h44, 32'h99);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_pc",    pc_o, 32'h0);
        chk("arst_valid", valid, 1'b0);
        chk("arst_instr", ifid_instr, 32'h0);
        chk("arst_ifpc",  ifid_pc, 32'h0);
        chk("arst_state", state, 2'b00);
        chk("arst_scnt",  stall_cnt, 4'd0);
        chk("arst_srun",  stall_run, 4'd0);
        chk("arst_fcnt",  flush_cnt, 4'd0);
        chk("arst_perr",  perr, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
